// File: rtl/soc_system_pio_capture.sv
// soc_system_pio_capture: Avalon-MM input PIO with per-bit edge capture,
// a maskable level IRQ, and a free-running cycle counter. The counter value
// is latched at the first edge of a burst so software can timestamp events.
module soc_system_pio_capture #(
    parameter int DATA_WIDTH    = 10,
    parameter int SYNC_STAGES   = 2,
    parameter int EDGE_TYPE     = 0,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_EDGE   = 3'd2;
    localparam logic [2:0] ADDR_TS_LO  = 3'd3;
    localparam logic [2:0] ADDR_TS_HI  = 3'd4;
    localparam logic [2:0] ADDR_CNT_LO = 3'd5;
    localparam logic [2:0] ADDR_CNT_HI = 3'd6;

    // Width of the counter portion that lives above bit 31.
    localparam int HI_WIDTH = COUNTER_WIDTH - 32;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    // Synchroniser chain; element SYNC_STAGES-1 is the settled pin value.
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
    logic [DATA_WIDTH-1:0]                  r_sync_d;
    logic [DATA_WIDTH-1:0]                  r_mask;
    logic [DATA_WIDTH-1:0]                  r_cap;
    logic [COUNTER_WIDTH-1:0]               r_cnt;
    logic [COUNTER_WIDTH-1:0]               r_ts;
    logic [HI_WIDTH-1:0]                    r_shadow;
    logic [31:0]                            r_readdata;

    logic [DATA_WIDTH-1:0] w_sync;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_cap_kept;
    logic [DATA_WIDTH-1:0] w_cap_next;
    logic                  w_first_edge;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wr_mask;
    logic                  w_wr_edge;
    logic                  w_wr_cnt;
    logic                  w_rd_cnt_lo;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Only the low DATA_WIDTH bits of writedata matter to any register.
    assign w_unused = ^writedata;

    // Bus strobes, qualified by chipselect.
    assign w_wr        = chipselect & ~write_n;
    assign w_rd        = chipselect & read;
    assign w_wr_mask   = w_wr && (address == ADDR_MASK);
    assign w_wr_edge   = w_wr && (address == ADDR_EDGE);
    assign w_wr_cnt    = w_wr && (address == ADDR_CNT_LO);
    assign w_rd_cnt_lo = w_rd && (address == ADDR_CNT_LO);

    // Edge polarity is fixed at elaboration time.
    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge = w_sync & ~r_sync_d;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge = ~w_sync & r_sync_d;
        end else begin : g_edge_any
            assign w_edge = w_sync ^ r_sync_d;
        end
    endgenerate

    // An edge arriving in the same cycle as a clear of that bit wins.
    assign w_clr        = w_wr_edge ? writedata[DATA_WIDTH-1:0] : '0;
    assign w_cap_kept   = r_cap & ~w_clr;
    assign w_cap_next   = w_cap_kept | w_edge;
    // Timestamp only the first edge of a burst (nothing left pending).
    assign w_first_edge = (|w_edge) && (w_cap_kept == '0);

    // IRQ is formed purely from registers, so the bus never reaches it combinationally.
    assign irq = |(r_cap & r_mask);

    // Register map read multiplexer; unused upper bits read as zero.
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:   w_rdata[DATA_WIDTH-1:0] = w_sync;
            ADDR_MASK:   w_rdata[DATA_WIDTH-1:0] = r_mask;
            ADDR_EDGE:   w_rdata[DATA_WIDTH-1:0] = r_cap;
            ADDR_TS_LO:  w_rdata                 = r_ts[31:0];
            ADDR_TS_HI:  w_rdata[HI_WIDTH-1:0]   = r_ts[COUNTER_WIDTH-1:32];
            ADDR_CNT_LO: w_rdata                 = r_cnt[31:0];
            ADDR_CNT_HI: w_rdata[HI_WIDTH-1:0]   = r_shadow;
            default:     w_rdata                 = '0;
        endcase
    end

    // Shift the asynchronous pins through the synchroniser and one history flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sync_d <= w_sync;
        end
    end

    // IRQ mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_wr_mask) begin
            r_mask <= writedata[DATA_WIDTH-1:0];
        end
    end

    // Sticky edge capture and first-event timestamp latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap <= '0;
            r_ts  <= '0;
        end else begin
            r_cap <= w_cap_next;
            if (w_first_edge) begin
                r_ts <= r_cnt;
            end
        end
    end

    // Free-running counter, software clearable; a CNT_LO read snapshots the upper half.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_shadow <= '0;
        end else begin
            if (w_wr_cnt) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_rd_cnt_lo) begin
                r_shadow <= r_cnt[COUNTER_WIDTH-1:32];
            end
        end
    end

    // Read data is reloaded from the addressed register every cycle, selected or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;

endmodule
